// File: rtl/enemy_2_renderer.sv
// Enemy-2 motion controller (bounce-and-descend, hit/respawn) and per-pixel sprite renderer.
// Optional `ENEMY_2_MIRROR_EN: draw the sprite horizontally mirrored while moving left.
module enemy_2_renderer #(
    parameter int ADDRESS        = 10,
    parameter int COLOR_BITS     = 24,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int X_START        = 0,
    parameter int Y_START        = 64,
    parameter int STEP_X         = 2,
    parameter int STEP_Y         = 16,
    parameter int RESPAWN_FRAMES = 120,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = 'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  video_on,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  hit,
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_data,
    output logic                  pix_valid,
    output logic [COLOR_BITS-1:0] pix_rgb,
    output logic [9:0]            enemy_x,
    output logic [9:0]            enemy_y,
    output logic                  alive
);

    localparam int HALF     = ADDRESS / 2;
    localparam int SPRITE_W = 1 << HALF;
    localparam int SPRITE_H = SPRITE_W;
    localparam int CNT_W    = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    typedef enum logic [1:0] {MOVE_R, MOVE_L, DEAD} state_t;

    state_t             state_q;
    logic [9:0]         x_q, y_q;
    logic               alive_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pix_valid_q;
    logic [COLOR_BITS-1:0] pix_rgb_q;

    logic               wall_r, wall_l;
    logic [9:0]         y_down_d;

    // Wall tests use 12-bit sums so x/y plus sprite size cannot wrap.
    always_comb begin
        wall_r = ({2'b00, x_q} + 12'(STEP_X) + 12'(SPRITE_W)) > 12'(SCREEN_W);
        wall_l = x_q < 10'(STEP_X);
        if (({2'b00, y_q} + 12'(STEP_Y) + 12'(SPRITE_H)) > 12'(SCREEN_H))
            y_down_d = 10'(Y_START);
        else
            y_down_d = y_q + 10'(STEP_Y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MOVE_R;
            x_q     <= 10'(X_START);
            y_q     <= 10'(Y_START);
            alive_q <= 1'b1;
            cnt_q   <= '0;
        end else if (hit && state_q != DEAD) begin
            // hit outranks a coincident frame_tick: no move is applied
            state_q <= DEAD;
            alive_q <= 1'b0;
            cnt_q   <= '0;
        end else if (frame_tick) begin
            case (state_q)
                MOVE_R: begin
                    if (wall_r) begin
                        x_q     <= 10'(SCREEN_W - SPRITE_W);
                        y_q     <= y_down_d;
                        state_q <= MOVE_L;
                    end else begin
                        x_q <= x_q + 10'(STEP_X);
                    end
                end
                MOVE_L: begin
                    if (wall_l) begin
                        x_q     <= '0;
                        y_q     <= y_down_d;
                        state_q <= MOVE_R;
                    end else begin
                        x_q <= x_q - 10'(STEP_X);
                    end
                end
                DEAD: begin
                    if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        x_q     <= 10'(X_START);
                        y_q     <= 10'(Y_START);
                        alive_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= MOVE_R;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= MOVE_R;
            endcase
        end
    end

    logic [9:0]      row, col;
    logic            in_box, draw;
    logic [HALF-1:0] col_idx;

    // Unsigned differences: scan positions left of / above the box wrap high and fail.
    always_comb begin
        row    = vcount - y_q;
        col    = hcount - x_q;
        in_box = (row < 10'(SPRITE_H)) && (col < 10'(SPRITE_W));
`ifdef ENEMY_2_MIRROR_EN
        col_idx = (state_q == MOVE_L) ? ~col[HALF-1:0] : col[HALF-1:0];
`else
        col_idx = col[HALF-1:0];
`endif
        rom_addr = in_box ? {row[HALF-1:0], col_idx} : '0;
        draw     = in_box && alive_q && video_on && (rom_data != TRANSPARENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            pix_rgb_q   <= '0;
        end else begin
            pix_valid_q <= draw;
            pix_rgb_q   <= draw ? rom_data : '0;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_rgb   = pix_rgb_q;
    assign enemy_x   = x_q;
    assign enemy_y   = y_q;
    assign alive     = alive_q;

endmodule

// File: tb/tb_enemy_2_renderer.sv
// Randomized self-checking bench for enemy_2_renderer against a frame-level motion/pixel model.
module tb_enemy_2_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hit = 1'b0;
    logic [9:0]  rom_addr;
    logic [23:0] rom_data;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [9:0]  enemy_x, enemy_y;
    logic        alive;

    logic [23:0] rom [1024];

    int checks = 0;
    int failures = 0;

    // model state
    int mx, my, mcnt;
    bit mleft, malive;
    bit         exp_valid;
    logic [23:0] exp_rgb;

    enemy_2_renderer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .video_on(video_on),
        .hcount(hcount), .vcount(vcount), .hit(hit), .rom_addr(rom_addr),
        .rom_data(rom_data), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .alive(alive)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 64; mcnt = 0; mleft = 0; malive = 1;
        exp_valid = 0; exp_rgb = '0;
    endtask

    task automatic step_down();
        if (my + 16 + 32 > 480) my = 64;
        else my = my + 16;
    endtask

    task automatic model_update(input bit t, input bit h);
        if (h && malive) begin
            malive = 0; mcnt = 0;
        end else if (t) begin
            if (!malive) begin
                if (mcnt == 119) begin
                    malive = 1; mx = 0; my = 64; mleft = 0; mcnt = 0;
                end else mcnt++;
            end else if (!mleft) begin
                if (mx + 2 + 32 > 640) begin mx = 608; step_down(); mleft = 1; end
                else mx += 2;
            end else begin
                if (mx < 2) begin mx = 0; step_down(); mleft = 0; end
                else mx -= 2;
            end
        end
    endtask

    function automatic logic [9:0] model_addr(input logic [9:0] h, input logic [9:0] v, output bit inb);
        logic [9:0] dh, dv;
        int c, r;
        dh = h - 10'(mx);
        dv = v - 10'(my);
        inb = (dh < 32) && (dv < 32);
        c = int'(dh) % 32;
        r = int'(dv) % 32;
`ifdef ENEMY_2_MIRROR_EN
        if (mleft) c = 31 - c;
`endif
        return inb ? 10'(r * 32 + c) : 10'd0;
    endfunction

    // One pixel cycle: starts and ends at a negedge.
    task automatic cycle(input bit t, input bit h, input logic [9:0] hc, input logic [9:0] vc, input bit von);
        logic [9:0] ea;
        bit inb;
        bit d;
        frame_tick = t; hit = h; hcount = hc; vcount = vc; video_on = von;
        #1;
        ea = model_addr(hc, vc, inb);
        check_eq("rom_addr", 32'(rom_addr), 32'(ea));
        d = inb && malive && von && (rom[ea] != 24'hFF00FF);
        @(posedge clk);
        model_update(t, h);
        exp_valid = d;
        exp_rgb = d ? rom[ea] : 24'h0;
        @(negedge clk);
        frame_tick = 0; hit = 0;
        check_eq("pix_valid", 32'(pix_valid), 32'(exp_valid));
        check_eq("pix_rgb", 32'(pix_rgb), 32'(exp_rgb));
        check_eq("enemy_x", 32'(enemy_x), 32'(mx));
        check_eq("enemy_y", 32'(enemy_y), 32'(my));
        check_eq("alive", 32'(alive), 32'(malive));
    endtask

    task automatic rand_scan(output logic [9:0] hc, output logic [9:0] vc);
        if ($urandom_range(0, 3) == 0) begin
            hc = 10'($urandom_range(0, 639));
            vc = 10'($urandom_range(0, 479));
        end else begin
            hc = 10'(mx + $urandom_range(0, 40) - 4);
            vc = 10'(my + $urandom_range(0, 40) - 4);
        end
    endtask

    task automatic ticks(input int n);
        logic [9:0] hc, vc;
        for (int i = 0; i < n; i++) begin
            rand_scan(hc, vc);
            cycle(1, 0, hc, vc, 1);
        end
    endtask

    task automatic do_reset();
        rst = 1; frame_tick = 0; hit = 0; video_on = 0; hcount = 0; vcount = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] hc, vc;
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 24'hFF00FF : 24'($urandom);
        rom[0] = 24'h123456;
        rom[1] = 24'hFF00FF;

        // reset state and first pixel
        do_reset();
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check_eq("rst_x", 32'(enemy_x), 32'd0);
        check_eq("rst_y", 32'(enemy_y), 32'd64);
        check_eq("rst_alive", 32'(alive), 32'd1);
        cycle(0, 0, 10'd0, 10'd64, 1);
        check_eq("first_rgb", 32'(pix_rgb), 32'h123456);
        check_eq("first_valid", 32'(pix_valid), 32'd1);
        cycle(0, 0, 10'd1, 10'd64, 1);
        check_eq("key_valid", 32'(pix_valid), 32'd0);
        check_eq("key_rgb", 32'(pix_rgb), 32'd0);
        cycle(0, 0, 10'd0, 10'd64, 0);
        check_eq("video_off", 32'(pix_valid), 32'd0);
        cycle(0, 0, 10'd1023, 10'd64, 1);
        cycle(0, 0, 10'd0, 10'd63, 1);
        cycle(0, 0, 10'd32, 10'd64, 1);

        // right-wall bounce
        ticks(304);
        check_eq("b304_x", 32'(enemy_x), 32'd608);
        check_eq("b304_y", 32'(enemy_y), 32'd64);
        ticks(1);
        check_eq("b305_x", 32'(enemy_x), 32'd608);
        check_eq("b305_y", 32'(enemy_y), 32'd80);
        ticks(1);
        check_eq("b306_x", 32'(enemy_x), 32'd606);
`ifdef ENEMY_2_MIRROR_EN
        ticks(253);
        check_eq("mir_x", 32'(enemy_x), 32'd100);
        cycle(0, 0, 10'd100, 10'(my), 1);
        frame_tick = 0; hit = 0; hcount = 10'd100; vcount = 10'(my); video_on = 1;
        #1;
        check_eq("mirror_col", 32'(rom_addr[4:0]), 32'd31);
        @(negedge clk);
`endif

        // hit at (40,64) and respawn, with a second hit while dead
        do_reset();
        ticks(20);
        check_eq("hit_pos_x", 32'(enemy_x), 32'd40);
        cycle(0, 1, 10'd40, 10'd64, 1);
        check_eq("hit_alive", 32'(alive), 32'd0);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 10'(40 + (i % 32)), 10'(64 + i / 2), 1);
            check_eq("dead_nopix", 32'(pix_valid), 32'd0);
        end
        ticks(50);
        cycle(0, 1, 10'd40, 10'd64, 1);
        ticks(69);
        check_eq("resp119_alive", 32'(alive), 32'd0);
        ticks(1);
        check_eq("resp_alive", 32'(alive), 32'd1);
        check_eq("resp_x", 32'(enemy_x), 32'd0);
        check_eq("resp_y", 32'(enemy_y), 32'd64);

        // simultaneous hit and tick at x=10
        ticks(5);
        cycle(1, 1, 10'd10, 10'd64, 1);
        check_eq("sim_x", 32'(enemy_x), 32'd10);
        check_eq("sim_alive", 32'(alive), 32'd0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            rand_scan(hc, vc);
            cycle($urandom_range(0, 1) == 0, $urandom_range(0, 150) == 0, hc, vc,
                  $urandom_range(0, 7) != 0);
        end

        // asynchronous reset mid-frame
        #2;
        rst = 1;
        #1;
        check_eq("arst_valid", 32'(pix_valid), 32'd0);
        check_eq("arst_rgb", 32'(pix_rgb), 32'd0);
        check_eq("arst_x", 32'(enemy_x), 32'd0);
        check_eq("arst_y", 32'(enemy_y), 32'd64);
        check_eq("arst_alive", 32'(alive), 32'd1);
        do_reset();
        cycle(0, 0, 10'd5, 10'd70, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enemy_2_renderer.md
# enemy_2_renderer

Per-pixel renderer and motion controller for the second enemy sprite. Each frame it moves the enemy across the screen in a bounce-and-descend pattern. Each pixel clock it compares the VGA timing generator's scan position with the enemy's bounding box and drives the address into the enemy-2 sprite ROM (asynchronous read, `ADDRESS`-bit address, `COLOR_BITS`-bit colour). It colour-keys the returned pixel and presents a registered, valid-qualified RGB value to the layer mixer.

## Interface

Parameters:
- `ADDRESS`, 10: sprite ROM address width; must be even. Sprite is square with side `SPRITE_W = 1<<(ADDRESS/2)` (32).
- `COLOR_BITS`, 24: pixel colour width.
- `SCREEN_W`, 640 / `SCREEN_H`, 480: visible area in pixels.
- `X_START`, 0 / `Y_START`, 64: spawn position, top-left corner.
- `STEP_X`, 2: horizontal pixels moved per frame.
- `STEP_Y`, 16: vertical pixels moved at each wall bounce.
- `RESPAWN_FRAMES`, 120: frames spent dead before respawn.
- `TRANSPARENT`, 24'hFF00FF: colour key; ROM words equal to it are not drawn.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blank.
- `video_on`, in, 1: high inside the visible area.
- `hcount`, in, 10: current pixel column.
- `vcount`, in, 10: current pixel row.
- `hit`, in, 1: one-cycle pulse from collision logic; destroys the enemy.
- `rom_addr`, out, `ADDRESS`: address to the sprite ROM.
- `rom_data`, in, `COLOR_BITS`: ROM output, valid in the same cycle as `rom_addr`.
- `pix_valid`, out, 1: an opaque enemy pixel is present on `pix_rgb`.
- `pix_rgb`, out, `COLOR_BITS`: enemy pixel colour.
- `enemy_x`, out, 10: registered enemy position, x.
- `enemy_y`, out, 10: registered enemy position, y.
- `alive`, out, 1: enemy is alive.

## Operation

- The FSM has three states: `MOVE_R`, `MOVE_L` and `DEAD`. State and position change only on `frame_tick` or `hit`.
- **`MOVE_R` on tick:**
  - If `x+STEP_X+SPRITE_W > SCREEN_W`: x = `SCREEN_W-SPRITE_W`, y steps down, go to `MOVE_L`.
  - Otherwise: x += `STEP_X`.
- **`MOVE_L` on tick:**
  - If `x < STEP_X`: x = 0, y steps down, go to `MOVE_R`.
  - Otherwise: x -= `STEP_X`.
- **Y step-down:** y += `STEP_Y`. If `y+STEP_Y+SPRITE_H > SCREEN_H`, y = `Y_START` instead (wrap to top).
- **`hit` in `MOVE_R` or `MOVE_L`:** go to `DEAD`, `alive` = 0, respawn counter = 0.
  - `hit` in `DEAD` is ignored.
  - If `hit` and `frame_tick` arrive in the same cycle, `hit` wins and no move is applied.
- **`DEAD` on tick:** counter += 1. When the counter reaches `RESPAWN_FRAMES-1`, x = `X_START`, y = `Y_START`, `alive` = 1, go to `MOVE_R`.
- **Bounding box:** `in_box` = (`hcount-x` < `SPRITE_W`) and (`vcount-y` < `SPRITE_W`). Use unsigned 10-bit subtraction, so coordinates left of or above the box underflow and fail the test.
- **ROM address:** `rom_addr` = {row[`ADDRESS/2`-1:0], col[`ADDRESS/2`-1:0]}, where row = `vcount-y` and col = `hcount-x`.
  - Combinational from `hcount`, `vcount` and the registered x/y.
  - Forced to 0 when `in_box` is 0.
- **Draw condition:** `draw` = `in_box` & `alive` & `video_on` & (`rom_data` != `TRANSPARENT`).
- **Output register:**
  - `pix_valid` <= `draw`.
  - `pix_rgb` <= `draw` ? `rom_data` : 0.

## Timing

- **Reset values:**
  - x = `X_START`, y = `Y_START`, state `MOVE_R`.
  - `alive` = 1, counter = 0.
  - `pix_valid` = 0, `pix_rgb` = 0, `rom_addr` = 0.
- **Pixel latency:** exactly 1 clock from `hcount`/`vcount` to `pix_valid`/`pix_rgb`. The downstream mixer delays its scan position by one cycle to match.
- **Position timing:** a position updated on `frame_tick` is visible on `enemy_x`/`enemy_y` the next cycle. It is constant for the whole visible frame, so no mid-frame tearing.
- **`hit` timing:** `hit` in cycle N drops `alive` in cycle N+1. `pix_valid` is 0 from cycle N+2.
- **Reset mid-frame:** outputs clear asynchronously, and the next visible pixel uses the spawn position.

## Configuration

- **`ENEMY_2_MIRROR_EN` defined:** while in `MOVE_L`, the column index is `SPRITE_W-1-(hcount-x)`, so the sprite is drawn horizontally mirrored. In `MOVE_R` it is unmirrored.
- **`ENEMY_2_MIRROR_EN` undefined:** the column index is always `hcount-x`, and the mirror logic is absent.

## Test plan

- **Reset and first pixel:** release reset with ROM word 0 = 24'h123456. Scan to (0,64) with `video_on`=1 → `rom_addr`=0 that cycle; the next cycle `pix_valid`=1 and `pix_rgb`=24'h123456.
- **Colour key:** ROM word = 24'hFF00FF inside the box → `pix_valid`=0 and `pix_rgb`=0.
- **Right-wall bounce (defaults):**
  - After 304 `frame_tick`s → `enemy_x`=608, `enemy_y`=64.
  - On the 305th tick → `enemy_x`=608, `enemy_y`=80, state `MOVE_L`.
  - On the 306th tick → `enemy_x`=606.
- **Hit and respawn:**
  - `hit` at position (40,64) → `alive`=0 the next cycle, and no `pix_valid` anywhere.
  - After 120 ticks → `alive`=1, position (0,64).
  - A second `hit` while dead has no effect.
- **Simultaneous `hit` and `frame_tick`** at x=10 → `DEAD`, and `enemy_x` stays 10.
- **Mirror (macro defined, `MOVE_L`, x=100):** scan (100, y) → `rom_addr` column field = 31.
